// File: rtl/i2c_slave_byte_ctrl.sv
// i2c_slave_byte_ctrl: byte-level I2C slave engine behind the SDA/SCL synchroniser.
// Performs 7-bit address match, receives write bytes with ACK/NACK and sends read bytes.
// sda_o/scl_o are open-drain enables: 1 releases the line, 0 pulls it low.
// Optional clock stretching on read underrun: define I2C_SLV_CLK_STRETCH_EN.
module i2c_slave_byte_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sta_det,
  input  logic       sto_det,
  input  logic       scl_rising,
  input  logic       scl_faling,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       scl_o,
  output logic       addr_hit,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_load,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    WAIT     = 3'd6
  } state_t;

  state_t     state_r;
  logic [3:0] bit_cnt_r;   // scl_rising index within the 9-clock frame
  logic [7:0] shift_r;     // RX: bits shifted in; TX: shift_r[7] is the next bit to drive
  logic       ack_r;       // ACK decision taken for the last write byte
  logic       load_pt_s;   // this clk is a LOAD point (or a pending stretched LOAD)

`ifdef I2C_SLV_CLK_STRETCH_EN
  logic scl_r;
  logic stretch_r;         // SCL held low waiting for tx_valid
  assign scl_o = scl_r;
`else
  assign scl_o = 1'b1;
`endif

  // Detect a LOAD point: the SCL fall ending an ACK clock ahead of a read byte
  always_comb begin
    load_pt_s = 1'b0;
    if (scl_faling && (bit_cnt_r == 4'd0) &&
        (((state_r == ADDR_ACK) && rw) || (state_r == RD_DATA))) begin
      load_pt_s = 1'b1;
    end else begin
      load_pt_s = 1'b0;
    end
`ifdef I2C_SLV_CLK_STRETCH_EN
    if (stretch_r) begin
      load_pt_s = 1'b1;
    end else begin
      load_pt_s = load_pt_s;
    end
`endif
  end

  // Protocol FSM: START/STOP handling, LOAD, address match, RX and TX bit sequencing
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      ack_r       <= 1'b0;
      sda_o       <= 1'b1;
      addr_hit    <= 1'b0;
      rw          <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_load     <= 1'b0;
      tx_underrun <= 1'b0;
`ifdef I2C_SLV_CLK_STRETCH_EN
      scl_r       <= 1'b1;
      stretch_r   <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      tx_load     <= 1'b0;
      tx_underrun <= 1'b0;
      if (sta_det) begin
        // START wins over a coincident STOP
        state_r   <= ADDR;
        bit_cnt_r <= 4'd0;
        sda_o     <= 1'b1;
        addr_hit  <= 1'b0;
`ifdef I2C_SLV_CLK_STRETCH_EN
        scl_r     <= 1'b1;
        stretch_r <= 1'b0;
`endif
      end else if (sto_det) begin
        state_r   <= IDLE;
        bit_cnt_r <= 4'd0;
        sda_o     <= 1'b1;
        addr_hit  <= 1'b0;
`ifdef I2C_SLV_CLK_STRETCH_EN
        scl_r     <= 1'b1;
        stretch_r <= 1'b0;
`endif
      end else if (load_pt_s) begin
        state_r   <= RD_DATA;
        bit_cnt_r <= 4'd0;
`ifdef I2C_SLV_CLK_STRETCH_EN
        if (tx_valid) begin
          shift_r   <= tx_data;
          sda_o     <= tx_data[7];
          tx_load   <= 1'b1;
          scl_r     <= 1'b1;
          stretch_r <= 1'b0;
        end else begin
          // hold SCL low, SDA untouched, until the byte arrives
          scl_r     <= 1'b0;
          stretch_r <= 1'b1;
        end
`else
        shift_r     <= tx_data;
        sda_o       <= tx_data[7];
        tx_load     <= 1'b1;
        tx_underrun <= ~tx_valid;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            sda_o <= 1'b1;
          end
          ADDR: begin
            if (scl_rising) begin
              shift_r   <= {shift_r[6:0], sda_i};
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                // shift_r[6:0] now holds the address, sda_i is R/W
                if (shift_r[6:0] == SLV_ADDR) begin
                  rw      <= sda_i;
                  state_r <= ADDR_ACK;
                end else begin
                  state_r <= WAIT;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_faling && (bit_cnt_r == 4'd8)) begin
              sda_o    <= 1'b0;
              addr_hit <= 1'b1;
            end else if (scl_rising) begin
              bit_cnt_r <= 4'd0;
            end else if (scl_faling) begin
              // write direction; the read direction leaves through load_pt_s
              sda_o   <= 1'b1;
              state_r <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (scl_rising) begin
              shift_r   <= {shift_r[6:0], sda_i};
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                rx_data  <= {shift_r[6:0], sda_i};
                rx_valid <= 1'b1;
                state_r  <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_faling && (bit_cnt_r == 4'd8)) begin
              sda_o <= ~rx_ack_en;
              ack_r <= rx_ack_en;
            end else if (scl_rising) begin
              bit_cnt_r <= 4'd0;
            end else if (scl_faling) begin
              sda_o   <= 1'b1;
              state_r <= ack_r ? WR_DATA : WAIT;
            end
          end
          RD_DATA: begin
            if (scl_rising) begin
              if (bit_cnt_r == 4'd8) begin
                // master ACK slot
                bit_cnt_r <= 4'd0;
                if (sda_i) begin
                  state_r <= WAIT;
                  sda_o   <= 1'b1;
                end
              end else begin
                // shifting on the rise moves the next TX bit into shift_r[7]
                shift_r   <= {shift_r[6:0], sda_i};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else if (scl_faling) begin
              if (bit_cnt_r == 4'd8) begin
                sda_o <= 1'b1;
              end else begin
                sda_o <= shift_r[7];
              end
            end
          end
          WAIT: begin
            sda_o <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
            sda_o   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Testbench for i2c_slave_byte_ctrl: table-driven write transactions plus
// hand-written read, repeated-START, START/STOP collision, underrun/stretch and reset sequences.
module tb_i2c_slave_byte_ctrl;

  logic       clk = 1'b0;
  logic       rstn, sta_det, sto_det, scl_rising, scl_faling, sda_i;
  logic       sda_o, scl_o, addr_hit, rw, rx_valid, rx_ack_en;
  logic [7:0] rx_data, tx_data;
  logic       tx_valid, tx_load, tx_underrun;

  int checks   = 0;
  int failures = 0;
  int rxv_cnt  = 0;
  int tl_cnt   = 0;
  int tu_cnt   = 0;
  int hi_viol  = 0;
  logic scl_hi   = 1'b0;
  logic sda_prev = 1'b1;

  i2c_slave_byte_ctrl #(.SLV_ADDR(7'h50)) dut (
    .clk(clk), .rstn(rstn), .sta_det(sta_det), .sto_det(sto_det),
    .scl_rising(scl_rising), .scl_faling(scl_faling), .sda_i(sda_i),
    .sda_o(sda_o), .scl_o(scl_o), .addr_hit(addr_hit), .rw(rw),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack_en(rx_ack_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_load(tx_load),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  // pulse counters and SDA-changes-while-SCL-high monitor
  always @(negedge clk) begin
    if (rx_valid)    rxv_cnt <= rxv_cnt + 1;
    if (tx_load)     tl_cnt  <= tl_cnt + 1;
    if (tx_underrun) tu_cnt  <= tu_cnt + 1;
    if (scl_hi && (sda_o !== sda_prev)) hi_viol <= hi_viol + 1;
    sda_prev <= sda_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rise(input logic b);
    sda_i = b; scl_rising = 1'b1; scl_hi = 1'b1;
    tick();
    scl_rising = 1'b0;
    tick(); tick();
  endtask

  task automatic fall();
    scl_faling = 1'b1; scl_hi = 1'b0;
    tick();
    scl_faling = 1'b0;
    tick(); tick();
  endtask

  // one SCL clock; obs is the slave's SDA drive while SCL is high
  task automatic clock_bit(input logic b, output logic obs);
    rise(b);
    obs = sda_o;
    fall();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] obs);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], o);
      obs[i] = o;
    end
  endtask

  task automatic start_cond(input logic with_stop);
    sta_det = 1'b1; sto_det = with_stop; scl_hi = 1'b0;
    tick();
    sta_det = 1'b0; sto_det = 1'b0;
    tick();
    fall();
  endtask

  task automatic stop_cond();
    sto_det = 1'b1; scl_hi = 1'b0;
    tick();
    sto_det = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       ack_en;
    logic       exp_aack;
    logic       exp_ack1;
    logic       exp_ack2;
    int         exp_rx;
    logic [7:0] exp_data;
    logic       exp_hit;
  } wr_vec_t;

  wr_vec_t vecs [6];

  initial begin
    logic [7:0] o1, o2, ob;
    logic       aack, a1, a2, hitm, rwm;
    int         rx0, tl0, tu0;

    vecs[0] = '{8'hA0, 8'h3C, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 2, 8'h11, 1'b1};
    vecs[1] = '{8'hA2, 8'h3C, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h11, 1'b0};
    vecs[2] = '{8'hA0, 8'h77, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h77, 1'b1};
    vecs[3] = '{8'hB0, 8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h77, 1'b0};
    vecs[4] = '{8'hA0, 8'h00, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 2, 8'hC3, 1'b1};
    vecs[5] = '{8'hA0, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'hFF, 1'b1};

    rstn = 1'b0; sta_det = 1'b0; sto_det = 1'b0; scl_rising = 1'b0; scl_faling = 1'b0;
    sda_i = 1'b1; rx_ack_en = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {sda_o, scl_o, addr_hit, rw, rx_valid, tx_load, tx_underrun, rx_data},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rstn = 1'b1;
    tick();

    // table-driven write transactions: address, two data bytes, STOP
    for (int i = 0; i < 6; i++) begin
      rx_ack_en = vecs[i].ack_en;
      rx0 = rxv_cnt;
      start_cond(1'b0);
      send_byte(vecs[i].addr_b, ob);
      clock_bit(1'b1, aack);
      hitm = addr_hit; rwm = rw;
      send_byte(vecs[i].d1, o1);
      clock_bit(1'b1, a1);
      send_byte(vecs[i].d2, o2);
      clock_bit(1'b1, a2);
      stop_cond();
      chk($sformatf("v%0d_addr_ack", i), aack, vecs[i].exp_aack);
      chk($sformatf("v%0d_d1_ack", i), a1, vecs[i].exp_ack1);
      chk($sformatf("v%0d_d2_ack", i), a2, vecs[i].exp_ack2);
      chk($sformatf("v%0d_sda_data", i), {ob, o1, o2}, 24'hFFFFFF);
      chk($sformatf("v%0d_rx_cnt", i), rxv_cnt - rx0, vecs[i].exp_rx);
      chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("v%0d_hit", i), hitm, vecs[i].exp_hit);
      chk($sformatf("v%0d_rw", i), rwm, 1'b0);
      chk($sformatf("v%0d_hit_stop", i), addr_hit, 1'b0);
    end
    rx_ack_en = 1'b1;

    // read 0xA5 (master ACK) then 0x0F (master NACK), then WAIT
    tx_data = 8'hA5; tx_valid = 1'b1;
    tl0 = tl_cnt; tu0 = tu_cnt;
    start_cond(1'b0);
    send_byte(8'hA1, ob);
    clock_bit(1'b1, aack);
    chk("rd_addr_ack", aack, 1'b0);
    chk("rd_rw", rw, 1'b1);
    chk("rd_hit", addr_hit, 1'b1);
    send_byte(8'hFF, o1);
    tx_data = 8'h0F;
    clock_bit(1'b0, a1);
    send_byte(8'hFF, o2);
    clock_bit(1'b1, a2);
    chk("rd_byte0", o1, 8'hA5);
    chk("rd_mack_release", a1, 1'b1);
    chk("rd_byte1", o2, 8'h0F);
    chk("rd_nack_release", a2, 1'b1);
    send_byte(8'hFF, ob);
    clock_bit(1'b0, a1);
    chk("rd_wait_sda", {ob, a1}, 9'h1FF);
    chk("rd_tx_load_cnt", tl_cnt - tl0, 2);
    chk("rd_underrun_cnt", tu_cnt - tu0, 0);
    stop_cond();
    chk("rd_hit_stop", addr_hit, 1'b0);

    // repeated START after 4 bits of a write byte, then read address
    rx0 = rxv_cnt;
    start_cond(1'b0);
    send_byte(8'hA0, ob);
    clock_bit(1'b1, aack);
    clock_bit(1'b1, a1); clock_bit(1'b0, a1); clock_bit(1'b1, a1); clock_bit(1'b0, a1);
    tx_data = 8'h3C;
    start_cond(1'b0);
    chk("rs_hit_cleared", addr_hit, 1'b0);
    send_byte(8'hA1, ob);
    clock_bit(1'b1, aack);
    chk("rs_addr_ack", aack, 1'b0);
    chk("rs_rw", rw, 1'b1);
    send_byte(8'hFF, o1);
    clock_bit(1'b1, a2);
    chk("rs_rd_byte", o1, 8'h3C);
    chk("rs_no_rx", rxv_cnt - rx0, 0);
    stop_cond();

    // coincident START+STOP: START must win
    start_cond(1'b0);
    send_byte(8'hA0, ob);
    clock_bit(1'b1, aack);
    start_cond(1'b1);
    send_byte(8'hA0, ob);
    clock_bit(1'b1, aack);
    chk("stasto_addr_ack", aack, 1'b0);
    chk("stasto_hit", addr_hit, 1'b1);
    stop_cond();

    // read with tx_valid low at the LOAD point
    tx_data = 8'h5A; tx_valid = 1'b0;
    tl0 = tl_cnt; tu0 = tu_cnt;
    start_cond(1'b0);
    send_byte(8'hA1, ob);
    clock_bit(1'b1, aack);
    chk("ur_addr_ack", aack, 1'b0);
`ifdef I2C_SLV_CLK_STRETCH_EN
    chk("st_scl_low", scl_o, 1'b0);
    repeat (20) tick();
    chk("st_scl_held", scl_o, 1'b0);
    chk("st_sda_held", sda_o, 1'b0);
    chk("st_no_load", tl_cnt - tl0, 0);
    tx_valid = 1'b1;
    begin
      int n = 0;
      while ((scl_o !== 1'b1) && (n < 10)) begin
        tick();
        n++;
      end
    end
    chk("st_scl_release", scl_o, 1'b1);
    chk("st_load_cnt", tl_cnt - tl0, 1);
    send_byte(8'hFF, o1);
    clock_bit(1'b1, a2);
    chk("st_rd_byte", o1, 8'h5A);
    chk("st_no_underrun", tu_cnt - tu0, 0);
`else
    chk("ur_underrun_cnt", tu_cnt - tu0, 1);
    chk("ur_load_cnt", tl_cnt - tl0, 1);
    chk("ur_scl_tied", scl_o, 1'b1);
    send_byte(8'hFF, o1);
    clock_bit(1'b1, a2);
    chk("ur_rd_byte", o1, 8'h5A);
    chk("ur_underrun_once", tu_cnt - tu0, 1);
`endif
    stop_cond();
    tx_valid = 1'b1;

    // reset while the slave is pulling SDA low during a read
    tx_data = 8'h00;
    start_cond(1'b0);
    send_byte(8'hA1, ob);
    clock_bit(1'b1, aack);
    chk("mr_sda_driven", sda_o, 1'b0);
    rstn = 1'b0;
    tick();
    chk("mr_outputs", {sda_o, scl_o, addr_hit, rw, rx_data}, {1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    rstn = 1'b1;
    tick(); tick();

    chk("sda_stable_scl_high", hi_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte_ctrl.md
Name: i2c_slave_byte_ctrl

Overview:
Byte-level I2C slave engine directly downstream of the bus debounce/synchroniser stage. It consumes the filtered sda_i, the scl_rising/scl_faling strobes and the sta_det/sto_det strobes. It performs 7-bit address match, receives write bytes with ACK/NACK and transmits read bytes. It returns open-drain enables sda_o/scl_o, where 1 releases the line and 0 pulls it low, back to the pad stage.

Parameters:
SLV_ADDR, 7'h50, 7-bit slave address compared against the first byte after START.

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
sta_det  input  1  START/repeated-START strobe, one clk
sto_det  input  1  STOP strobe, one clk
scl_rising  input  1  SCL rising-edge strobe; sda_i sampled here
scl_faling  input  1  SCL falling-edge strobe; sda_o updated here
sda_i  input  1  filtered SDA level
sda_o  output  1  SDA drive enable (0 = pull low)
scl_o  output  1  SCL drive enable (0 = stretch)
addr_hit  output  1  high from address-ACK until STOP or next START
rw  output  1  R/W bit latched with a matching address (1 = read)
rx_data  output  8  last received write byte
rx_valid  output  1  one-clk pulse, rx_data updated
rx_ack_en  input  1  1 = ACK received byte, 0 = NACK
tx_data  input  8  next read byte
tx_valid  input  1  tx_data is valid
tx_load  output  1  one-clk pulse, tx_data consumed
tx_underrun  output  1  one-clk pulse, byte loaded while tx_valid=0

Behaviour:
- Clock/reset: one clock clk; reset synchronous, active-low (rstn).
- Reset values: sda_o=1, scl_o=1, addr_hit=0, rw=0, rx_data=0, rx_valid=0, tx_load=0, tx_underrun=0, state=IDLE, bit_cnt=0.
- Internal: 8-bit shift register; 4-bit bit_cnt counts scl_rising 0..8 within a 9-clock frame (8 data + ACK).
- Event priority each clk: rstn > sta_det > sto_det > scl_rising/scl_faling.
- sta_det in any state: state=ADDR, bit_cnt=0, sda_o=1, addr_hit=0, scl_o=1.
- sto_det in any state: state=IDLE, sda_o=1, scl_o=1, addr_hit=0.
- IDLE: ignore edge strobes.
- ADDR: shift sda_i MSB-first on each scl_rising. After the 8th rising edge, compare shift[7:1] with SLV_ADDR.
  - Match: latch rw=shift[0] and go to ADDR_ACK.
  - Mismatch: go to WAIT.
- ADDR_ACK: first scl_faling sets sda_o=0 and addr_hit=1. 9th scl_rising has no action. Next scl_faling then:
  - rw=0: sda_o=1, go to WR_DATA.
  - rw=1: perform LOAD, go to RD_DATA.
- LOAD, in the same clk as the scl_faling: shift=tx_data, sda_o=tx_data[7], tx_load=1. If tx_valid=0, also tx_underrun=1 (see Optional Feature).
- WR_DATA: shift on each scl_rising.
  - After the 8th rising: rx_data=shift, rx_valid=1 for 1 clk, go to WR_ACK.
  - WR_ACK: next scl_faling sets sda_o=~rx_ack_en, sampled that clk. Following scl_faling sets sda_o=1; go to WR_DATA if ACKed, else WAIT.
- RD_DATA: each scl_faling shifts left and drives the next bit on sda_o. The scl_faling after bit 8 sets sda_o=1 (release for master ACK).
  - 9th scl_rising samples sda_i. 0 (ACK): next scl_faling performs LOAD and stays in RD_DATA. 1 (NACK): go to WAIT with sda_o=1.
- WAIT: sda_o=1, ignore strobes until sta_det or sto_det.
- Simultaneous sta_det and sto_det (glitch): START wins.
- sda_o must change only on the scl_faling clk, or on sta/sto/reset. Never drive SDA while SCL is high.
- Reset asserted mid-transfer: all outputs return to reset values on the next clk edge; bus released.

Optional Feature:
- Macro I2C_SLV_CLK_STRETCH_EN.
- Defined: at a LOAD point with tx_valid=0, set scl_o=0 and hold SCL low with sda_o unchanged. When tx_valid=1 is seen, perform LOAD and set scl_o=1 in the same clk. tx_underrun is never asserted. sta_det/sto_det/reset release scl_o.
- Undefined: scl_o is tied 1. LOAD takes tx_data regardless of tx_valid and pulses tx_underrun when tx_valid=0.

Test Plan:
- Write to 0x50 (byte 0xA0), data 0x3C, rx_ack_en=1, STOP -> ACK on both 9th clocks; rx_valid pulse with rx_data=0x3C; addr_hit 1 then 0 after STOP; state IDLE.
- START, address 0x51 -> sda_o stays 1 the whole frame; no rx_valid/tx_load; WAIT until STOP.
- Read from 0x50 (0xA1), tx_data=0xA5 then 0x0F, master ACK then NACK -> SDA carries 10100101 then 00001111; two tx_load pulses; WAIT after NACK.
- Write 0x50, data 0x77 with rx_ack_en=0 -> sda_o=1 on 9th clock; state WAIT; next data byte ignored.
- Repeated START mid-write byte (after 4 bits) followed by read address 0xA1 -> bit_cnt restarts; address ACKed; rw=1.
- Read with tx_valid=0 at LOAD: macro defined -> scl_o=0 until tx_valid raised 20 clks later, then byte sent; macro undefined -> 0xFF-or-tx_data sent and tx_underrun pulses once.
